layer3_mac_seq: RTL and testbench

Sequencer that computes one signed dot product per command by streaming operand pairs from two on-chip buffers through the shared Layer 3 16x16 signed multiplier and accumulating the products. It sits between the Layer 3 control logic, which issues one command per output neuron, and the combinational DSP48 multiplier instance. It owns the buffer read ports and the multiplier operands for the duration of a command, and returns a 32-bit result over a valid/ready handshake.

---
 rtl/layer3_mac_seq.sv | 139 +++++++++++++
 tb/tb_layer3_mac_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer3_mac_seq.sv
// layer3_mac_seq: streams operand pairs from two buffers through the shared 16x16
// multiplier and accumulates a signed dot product. Define LAYER3_MAC_SAT_EN to saturate res_data.
module layer3_mac_seq #(
   parameter int ADDR_W = 10,
   parameter int ACC_W  = 42
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        len,
   input  logic [ADDR_W-1:0]        base_a,
   input  logic [ADDR_W-1:0]        base_b,
   output logic                     busy,
   output logic                     a_ce,
   output logic                     b_ce,
   output logic [ADDR_W-1:0]        a_addr,
   output logic [ADDR_W-1:0]        b_addr,
   input  logic signed [15:0]       a_q,
   input  logic signed [15:0]       b_q,
   output logic signed [15:0]       mul_din0,
   output logic signed [15:0]       mul_din1,
   input  logic signed [31:0]       mul_dout,
   output logic [31:0]              res_data,
   output logic                     res_valid,
   input  logic                     res_ready
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | issuing one operand pair per cycle
   // DRAIN | waiting for the multiply/accumulate pipeline to empty
   // OUT   | presenting the result until res_ready
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t                    r_state;
   logic [ADDR_W-1:0]         r_rem;
   logic [ADDR_W-1:0]         r_a_addr;
   logic [ADDR_W-1:0]         r_b_addr;
   logic                      r_ce;
   logic                      r_busy;
   logic                      r_valid;
   logic                      r_v1;
   logic                      r_v2;
   logic signed [31:0]        r_p;
   logic signed [ACC_W-1:0]   r_acc;
   logic [31:0]               w_res;

   assign mul_din0  = a_q;
   assign mul_din1  = b_q;
   assign a_ce      = r_ce;
   assign b_ce      = r_ce;
   assign a_addr    = r_a_addr;
   assign b_addr    = r_b_addr;
   assign busy      = r_busy;
   assign res_valid = r_valid;
   assign res_data  = w_res;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state  <= S_IDLE;
         r_rem    <= '0;
         r_a_addr <= '0;
         r_b_addr <= '0;
         r_ce     <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_p      <= '0;
         r_acc    <= '0;
      end else begin
         r_v1 <= r_ce;
         r_v2 <= r_v1;
         if (r_v1) r_p <= mul_dout;
         if (r_v2) r_acc <= r_acc + {{(ACC_W-32){r_p[31]}}, r_p};
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rem    <= len - ONE;
                  r_a_addr <= base_a;
                  r_b_addr <= base_b;
                  r_acc    <= '0;
                  r_busy   <= 1'b1;
                  if (len != '0) begin
                     r_ce    <= 1'b1;
                     r_state <= S_RUN;
                  end else begin
                     r_valid <= 1'b1;
                     r_state <= S_OUT;
                  end
               end
            end
            S_RUN: begin
               if (r_rem == '0) begin
                  r_ce    <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  r_rem    <= r_rem - ONE;
                  r_a_addr <= r_a_addr + ONE;
                  r_b_addr <= r_b_addr + ONE;
               end
            end
            // v1 low means no product is left to load; the last one lands in acc on this edge
            S_DRAIN: begin
               if (!r_v1) begin
                  r_valid <= 1'b1;
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef LAYER3_MAC_SAT_EN
   logic [ACC_W-32:0] w_hi;
   assign w_hi = r_acc[ACC_W-1:31];
   always_comb begin
      w_res = r_acc[31:0];
      if (!((&w_hi) || !(|w_hi))) begin
         w_res = r_acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end
`else
   logic w_acc_hi_unused;
   assign w_acc_hi_unused = ^r_acc[ACC_W-1:32];
   assign w_res = r_acc[31:0];
`endif

endmodule

// File: tb/tb_layer3_mac_seq.sv
// tb_layer3_mac_seq: directed bench with buffer/multiplier models and a result scoreboard.
module tb_layer3_mac_seq;

   logic               ap_clk = 1'b0;
   logic               ap_rst_n = 1'b0;
   logic               start = 1'b0;
   logic [9:0]         len = '0;
   logic [9:0]         base_a = '0;
   logic [9:0]         base_b = '0;
   logic               busy;
   logic               a_ce, b_ce;
   logic [9:0]         a_addr, b_addr;
   logic signed [15:0] a_q = '0;
   logic signed [15:0] b_q = '0;
   logic signed [15:0] mul_din0, mul_din1;
   logic signed [31:0] mul_dout;
   logic [31:0]        res_data;
   logic               res_valid;
   logic               res_ready = 1'b1;

   logic signed [15:0] mem_a [1024];
   logic signed [15:0] mem_b [1024];

   int                 n_chk = 0;
   int                 n_pass = 0;
   logic [31:0]        sb[$];
   int                 qa[$];
   int                 qb[$];

   layer3_mac_seq dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .len(len),
      .base_a(base_a), .base_b(base_b), .busy(busy), .a_ce(a_ce), .b_ce(b_ce),
      .a_addr(a_addr), .b_addr(b_addr), .a_q(a_q), .b_q(b_q),
      .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      if (a_ce) a_q <= mem_a[a_addr];
      if (b_ce) b_q <= mem_b[b_addr];
   end

   assign mul_dout = mul_din0 * mul_din1;

   function automatic logic [31:0] model(input logic [9:0] ba, input logic [9:0] bb, input int l);
      logic signed [41:0] acc;
      logic signed [31:0] p;
      acc = '0;
      for (int i = 0; i < l; i++) begin
         p = mem_a[10'(ba + i)] * mem_b[10'(bb + i)];
         acc += p;
      end
`ifdef LAYER3_MAC_SAT_EN
      if (acc > 42'sd2147483647) return 32'h7FFF_FFFF;
      if (acc < -42'sd2147483648) return 32'h8000_0000;
`endif
      return acc[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic launch(input logic [9:0] l, input logic [9:0] ba, input logic [9:0] bb);
      @(negedge ap_clk);
      start = 1'b1; len = l; base_a = ba; base_b = bb;
      @(negedge ap_clk);
      start = 1'b0;
   endtask

   // Called at the negedge of cycle 1; returns the cycle in which res_valid is first seen.
   task automatic wait_valid(output int seen, output int ce_n);
      seen = -1;
      ce_n = 0;
      qa.delete();
      qb.delete();
      for (int i = 1; i <= 64; i++) begin
         if (a_ce) begin
            ce_n++;
            qa.push_back(int'(a_addr));
            qb.push_back(int'(b_addr));
         end
         if (res_valid) begin
            seen = i;
            break;
         end
         @(negedge ap_clk);
      end
   endtask

   task automatic accept(input string tag);
      logic [31:0] e;
      e = 32'hDEAD_BEEF;
      if (sb.size() > 0) e = sb.pop_front();
      res_ready = 1'b1;
      chk(tag, res_data, e);
      @(negedge ap_clk);
      chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
      chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int seen, ce_n, busy_n, xfer_n;
      logic [31:0] held;
      int exp_a [4];
      int exp_b [4];

      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 16'(i * 7 - 300);
         mem_b[i] = 16'(i * 3 + 11);
      end

      // reset values
      repeat (3) @(negedge ap_clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ce", {30'd0, a_ce, b_ce}, 32'd0);
      chk("rst_addr", {6'd0, a_addr, 6'd0, b_addr}, 32'd0);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_data", res_data, 32'd0);
      ap_rst_n = 1'b1;

      // basic dot product: 1*5+2*6+3*7+4*8
      for (int i = 0; i < 4; i++) begin
         mem_a[i] = 16'(i + 1);
         mem_b[100 + i] = 16'(i + 5);
      end
      sb.push_back(32'd70);
      launch(10'd4, 10'd0, 10'd100);
      chk("basic_busy", {31'd0, busy}, 32'd1);
      wait_valid(seen, ce_n);
      chk("basic_vcyc", 32'(seen), 32'd7);
      chk("basic_ce_cnt", 32'(ce_n), 32'd4);
      accept("basic_data");

      // empty command
      sb.push_back(32'd0);
      launch(10'd0, 10'd50, 10'd60);
      wait_valid(seen, ce_n);
      chk("empty_vcyc", 32'(seen), 32'd1);
      chk("empty_ce_cnt", 32'(ce_n), 32'd0);
      accept("empty_data");

      // overflow: 4 * 2^30 = 2^32
      for (int i = 0; i < 4; i++) begin
         mem_a[200 + i] = -16'sd32768;
         mem_b[300 + i] = -16'sd32768;
      end
`ifdef LAYER3_MAC_SAT_EN
      sb.push_back(32'h7FFF_FFFF);
`else
      sb.push_back(32'h0000_0000);
`endif
      launch(10'd4, 10'd200, 10'd300);
      wait_valid(seen, ce_n);
      chk("ovf_vcyc", 32'(seen), 32'd7);
      accept("ovf_data");

      // address wrap
      mem_a[1022] = 16'sd10;
      mem_a[1023] = -16'sd20;
      for (int i = 0; i < 4; i++) mem_b[5 + i] = 16'(i + 3);
      exp_a = '{1022, 1023, 0, 1};
      exp_b = '{5, 6, 7, 8};
      sb.push_back(model(10'd1022, 10'd5, 4));
      launch(10'd4, 10'd1022, 10'd5);
      wait_valid(seen, ce_n);
      chk("wrap_ce_cnt", 32'(qa.size()), 32'd4);
      for (int i = 0; i < 4 && i < qa.size(); i++) begin
         chk($sformatf("wrap_a_addr%0d", i), 32'(qa[i]), 32'(exp_a[i]));
         chk($sformatf("wrap_b_addr%0d", i), 32'(qb[i]), 32'(exp_b[i]));
      end
      accept("wrap_data");

      // backpressure with an ignored start pulse
      res_ready = 1'b0;
      sb.push_back(model(10'd0, 10'd100, 2));
      launch(10'd2, 10'd0, 10'd100);
      wait_valid(seen, ce_n);
      chk("bp_vcyc", 32'(seen), 32'd5);
      held = res_data;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            start = 1'b1; len = 10'd3; base_a = 10'd7; base_b = 10'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge ap_clk);
         chk($sformatf("bp_hold%0d", i), res_data, held);
         chk($sformatf("bp_busy%0d", i), {30'd0, busy, res_valid}, 32'd3);
      end
      start = 1'b0;
      xfer_n = (res_valid && res_ready) ? 1 : 0;
      xfer_n = xfer_n + 1;
      accept("bp_data");
      busy_n = 0;
      for (int i = 0; i < 6; i++) begin
         if (busy) busy_n++;
         if (res_valid && res_ready) xfer_n++;
         @(negedge ap_clk);
      end
      chk("bp_no_restart", 32'(busy_n), 32'd0);
      chk("bp_one_xfer", 32'(xfer_n), 32'd1);

      // reset mid-command, then a clean follow-up
      launch(10'd8, 10'd0, 10'd100);
      @(negedge ap_clk);
      @(negedge ap_clk);
      chk("mid_running", {31'd0, a_ce}, 32'd1);
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ce", {30'd0, a_ce, b_ce}, 32'd0);
      chk("mid_rst_addr", {6'd0, a_addr, 6'd0, b_addr}, 32'd0);
      chk("mid_rst_out", {res_valid, res_data[30:0]} | {31'd0, |res_data}, 32'd0);
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      mem_a[400] = 16'sd3; mem_a[401] = 16'sd4;
      mem_b[500] = 16'sd3; mem_b[501] = 16'sd4;
      sb.push_back(32'd25);
      launch(10'd2, 10'd400, 10'd500);
      wait_valid(seen, ce_n);
      chk("post_rst_vcyc", 32'(seen), 32'd5);
      accept("post_rst_data");
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
